// File: rtl/teclado_matricial_calc.sv
// 4x4 active-low matrix keypad scanner for the calculator: synchronizes and debounces the rows,
// then turns each accepted press into a single digit or operator pulse.
module teclado_matricial_calc #(
   parameter int SCAN_DIV        = 16,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] filas,
   output logic [3:0] columnas,
   output logic [3:0] digito,
   output logic       digito_en,
   output logic [1:0] que_operacion,
   output logic       operando_en
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, HOLD} state_t;

   state_t        state_reg, state_next;
   logic [1:0]    col_idx_reg, col_idx_next;
   logic [1:0]    row_reg, row_next;
   logic [DW-1:0] dwell_reg, dwell_next;
   logic [CW-1:0] deb_cnt_reg, deb_cnt_next;
   logic [3:0]    sync_reg, rs_reg;
   logic [3:0]    columnas_next, digito_next;
   logic [1:0]    que_operacion_next;
   logic          digito_en_next, operando_en_next;

   logic [1:0]    row_low;
   logic          key_is_digit, key_is_op;
   logic [3:0]    key_val;

   // Lowest-index low row wins when several rows are pulled down together.
   always_comb begin
      row_low = 2'd3;
      if (!rs_reg[0])      row_low = 2'd0;
      else if (!rs_reg[1]) row_low = 2'd1;
      else if (!rs_reg[2]) row_low = 2'd2;
   end

   always_comb begin
      key_is_digit = 1'b0;
      key_is_op    = 1'b0;
      key_val      = 4'd0;
      case ({row_reg, col_idx_reg})
         4'b00_00: begin key_is_digit = 1'b1; key_val = 4'd1; end
         4'b00_01: begin key_is_digit = 1'b1; key_val = 4'd2; end
         4'b00_10: begin key_is_digit = 1'b1; key_val = 4'd3; end
         4'b00_11: begin key_is_op    = 1'b1; key_val = 4'd1; end
         4'b01_00: begin key_is_digit = 1'b1; key_val = 4'd4; end
         4'b01_01: begin key_is_digit = 1'b1; key_val = 4'd5; end
         4'b01_10: begin key_is_digit = 1'b1; key_val = 4'd6; end
         4'b01_11: begin key_is_op    = 1'b1; key_val = 4'd2; end
         4'b10_00: begin key_is_digit = 1'b1; key_val = 4'd7; end
         4'b10_01: begin key_is_digit = 1'b1; key_val = 4'd8; end
         4'b10_10: begin key_is_digit = 1'b1; key_val = 4'd9; end
         4'b10_11: begin key_is_op    = 1'b1; key_val = 4'd3; end
         4'b11_01: begin key_is_digit = 1'b1; key_val = 4'd0; end
         default:  begin key_is_digit = 1'b0; key_is_op = 1'b0; end
      endcase
   end

   always_comb begin
      state_next         = state_reg;
      col_idx_next       = col_idx_reg;
      row_next           = row_reg;
      dwell_next         = dwell_reg;
      deb_cnt_next       = deb_cnt_reg;
      digito_next        = digito;
      que_operacion_next = que_operacion;
      digito_en_next     = 1'b0;
      operando_en_next   = 1'b0;
      case (state_reg)
         SCAN: begin
            if (dwell_reg == DWELL_LAST) begin
               dwell_next = '0;
               if (rs_reg != 4'hF) begin
                  row_next     = row_low;
                  deb_cnt_next = '0;
                  state_next   = DEBOUNCE;
               end else begin
                  col_idx_next = col_idx_reg + 2'd1;
               end
            end else begin
               dwell_next = dwell_reg + DW'(1);
            end
         end
         DEBOUNCE: begin
            if (rs_reg[row_reg]) begin
               dwell_next = '0;
               state_next = SCAN;
            end else if (deb_cnt_reg == DEB_LAST) begin
               state_next = EMIT;
            end else begin
               deb_cnt_next = deb_cnt_reg + CW'(1);
            end
         end
         EMIT: begin
            if (key_is_digit) begin
               digito_next    = key_val;
               digito_en_next = 1'b1;
            end
            if (key_is_op) begin
               que_operacion_next = key_val[1:0];
               operando_en_next   = 1'b1;
            end
            deb_cnt_next = '0;
            state_next   = HOLD;
         end
         HOLD: begin
            // Only a full release of every row, held stable, ends the press.
            if (rs_reg == 4'hF) begin
               if (deb_cnt_reg == DEB_LAST) begin
                  deb_cnt_next = '0;
                  col_idx_next = col_idx_reg + 2'd1;
                  dwell_next   = '0;
                  state_next   = SCAN;
               end else begin
                  deb_cnt_next = deb_cnt_reg + CW'(1);
               end
            end else begin
               deb_cnt_next = '0;
            end
         end
         default: state_next = SCAN;
      endcase
      columnas_next = ~(4'b0001 << col_idx_next);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_reg      <= 4'hF;
         rs_reg        <= 4'hF;
         state_reg     <= SCAN;
         col_idx_reg   <= 2'd0;
         row_reg       <= 2'd0;
         dwell_reg     <= '0;
         deb_cnt_reg   <= '0;
         columnas      <= 4'b1110;
         digito        <= 4'd0;
         digito_en     <= 1'b0;
         que_operacion <= 2'd0;
         operando_en   <= 1'b0;
      end else begin
         sync_reg      <= filas;
         rs_reg        <= sync_reg;
         state_reg     <= state_next;
         col_idx_reg   <= col_idx_next;
         row_reg       <= row_next;
         dwell_reg     <= dwell_next;
         deb_cnt_reg   <= deb_cnt_next;
         columnas      <= columnas_next;
         digito        <= digito_next;
         digito_en     <= digito_en_next;
         que_operacion <= que_operacion_next;
         operando_en   <= operando_en_next;
      end
   end

endmodule

// File: tb/tb_teclado_matricial_calc.sv
// Bench for teclado_matricial_calc: a keypad model drives filas from columnas, expected events
// are queued when keys are pressed and matched against the pulses the scanner emits.
module tb_teclado_matricial_calc;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] filas;
   logic [3:0] columnas;
   logic [3:0] digito;
   logic       digito_en;
   logic [1:0] que_operacion;
   logic       operando_en;

   logic [3:0][3:0] keys = '0;   // keys[row][col] pressed
   int n_cmp = 0;
   int n_fail = 0;

   typedef struct packed {
      logic       is_op;
      logic [3:0] val;
   } ev_t;
   ev_t sb[$];

   typedef struct {
      int         row;
      int         col;
      int         hold;
      bit         has_ev;
      bit         is_op;
      logic [3:0] val;
   } vec_t;

   logic [3:0] model_digit = 4'd0;
   logic [1:0] model_op = 2'd0;
   logic       rst_at_edge = 1'b1;

   teclado_matricial_calc #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
      .clk(clk),
      .reset(reset),
      .filas(filas),
      .columnas(columnas),
      .digito(digito),
      .digito_en(digito_en),
      .que_operacion(que_operacion),
      .operando_en(operando_en)
   );

   always #5 clk = ~clk;

   always_comb begin
      filas = 4'hF;
      for (int r = 0; r < 4; r++)
         filas[r] = ~|(keys[r] & ~columnas);
   end

   always @(posedge clk) rst_at_edge <= reset;

   function automatic logic [3:0] col_pat(input int col);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << col);
   endfunction

   task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %b, required %b", name, act, req);
      end
   endtask

   // Monitor: pops the scoreboard on every pulse and checks held values otherwise.
   initial begin
      ev_t ev;
      forever begin
         @(negedge clk);
         if (rst_at_edge) begin
            model_digit = 4'd0;
            model_op    = 2'd0;
         end else begin
            n_cmp++;
            if (digito_en && operando_en) begin
               n_fail++;
               $display("FAIL pulse_excl: got digito_en=1 operando_en=1, required at most one");
            end
            if (digito_en || operando_en) begin
               n_cmp++;
               if (sb.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_pulse: got digito_en=%0b operando_en=%0b digito=%0d op=%0d, required no pulse",
                           digito_en, operando_en, digito, que_operacion);
               end else begin
                  ev = sb.pop_front();
                  if (ev.is_op) begin
                     if (!operando_en || que_operacion !== ev.val[1:0] || digito !== model_digit) begin
                        n_fail++;
                        $display("FAIL op_event: got operando_en=%0b op=%0d digito=%0d, required operando_en=1 op=%0d digito=%0d",
                                 operando_en, que_operacion, digito, ev.val[1:0], model_digit);
                     end
                     model_op = ev.val[1:0];
                     $display("event operator: got %0d expected %0d", que_operacion, ev.val[1:0]);
                  end else begin
                     if (!digito_en || digito !== ev.val || que_operacion !== model_op) begin
                        n_fail++;
                        $display("FAIL digit_event: got digito_en=%0b digito=%0d op=%0d, required digito_en=1 digito=%0d op=%0d",
                                 digito_en, digito, que_operacion, ev.val, model_op);
                     end
                     model_digit = ev.val;
                     $display("event digit: got %0d expected %0d", digito, ev.val);
                  end
               end
            end else begin
               n_cmp++;
               if (digito !== model_digit || que_operacion !== model_op) begin
                  n_fail++;
                  $display("FAIL held_value: got digito=%0d op=%0d, required digito=%0d op=%0d",
                           digito, que_operacion, model_digit, model_op);
               end
            end
         end
      end
   end

   // Wait for a fresh entry into column col (dwell starts at zero there).
   task automatic wait_col(input int col);
      int n;
      n = 0;
      while (columnas == col_pat(col) && n < 64) begin @(negedge clk); n++; end
      while (columnas != col_pat(col) && n < 128) begin @(negedge clk); n++; end
      check4("wait_col", columnas, col_pat(col));
   endtask

   task automatic press(input vec_t v);
      int n;
      ev_t ev;
      wait_col(v.col);
      keys[v.row][v.col] = 1'b1;
      if (v.has_ev) begin
         ev.is_op = v.is_op;
         ev.val   = v.val;
         sb.push_back(ev);
      end
      repeat (v.hold) @(negedge clk);
      check4("col_frozen", columnas, col_pat(v.col));
      check4("pulse_done", 4'(sb.size()), 4'd0);
      keys = '0;
      n = 0;
      while (columnas == col_pat(v.col) && n < 60) begin @(negedge clk); n++; end
      check4("col_advance", columnas, col_pat((v.col + 1) % 4));
   endtask

   initial begin
      vec_t tbl[7];
      ev_t  ev;
      tbl[0] = '{row: 1, col: 1, hold: 40, has_ev: 1, is_op: 0, val: 4'd5};
      tbl[1] = '{row: 2, col: 0, hold: 20, has_ev: 1, is_op: 0, val: 4'd7};
      tbl[2] = '{row: 1, col: 3, hold: 20, has_ev: 1, is_op: 1, val: 4'd2};
      tbl[3] = '{row: 0, col: 1, hold: 20, has_ev: 1, is_op: 0, val: 4'd2};
      tbl[4] = '{row: 2, col: 3, hold: 20, has_ev: 1, is_op: 1, val: 4'd3};
      tbl[5] = '{row: 3, col: 2, hold: 20, has_ev: 0, is_op: 0, val: 4'd0};
      tbl[6] = '{row: 0, col: 2, hold: 20, has_ev: 1, is_op: 0, val: 4'd3};

      // Reset state and idle scan
      repeat (3) @(negedge clk);
      check4("rst_columnas", columnas, 4'b1110);
      check4("rst_digito", digito, 4'd0);
      check4("rst_op", {2'b00, que_operacion}, 4'd0);
      check4("rst_pulses", {2'b00, digito_en, operando_en}, 4'd0);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i > 0) @(negedge clk);
         check4("scan_seq", columnas, col_pat((i / 4) % 4));
      end

      for (int i = 0; i < 7; i++) begin
         press(tbl[i]);
         repeat (10) @(negedge clk);
      end

      // Bouncing "+" followed by a stable press
      wait_col(3);
      for (int i = 0; i < 20; i++) begin
         keys[0][3] = ((i / 3) % 2 == 0);
         @(negedge clk);
      end
      check4("bounce_no_pulse", 4'(sb.size()), 4'd0);
      keys[0][3] = 1'b1;
      ev = '{is_op: 1'b1, val: 4'd1};
      sb.push_back(ev);
      repeat (40) @(negedge clk);
      check4("bounce_pulse", 4'(sb.size()), 4'd0);
      keys = '0;
      repeat (30) @(negedge clk);

      // Two rows in column 0, then "9" pressed while still held
      wait_col(0);
      keys[0][0] = 1'b1;
      keys[2][0] = 1'b1;
      ev = '{is_op: 1'b0, val: 4'd1};
      sb.push_back(ev);
      repeat (20) @(negedge clk);
      keys[2][2] = 1'b1;
      repeat (15) @(negedge clk);
      check4("hold_ignores_9", columnas, 4'b1110);
      check4("multi_one_pulse", 4'(sb.size()), 4'd0);
      keys[0][0] = 1'b0;
      keys[2][0] = 1'b0;
      ev = '{is_op: 1'b0, val: 4'd9};
      sb.push_back(ev);
      repeat (45) @(negedge clk);
      check4("nine_after_release", 4'(sb.size()), 4'd0);
      keys = '0;
      repeat (30) @(negedge clk);

      // Reset three cycles into the debounce of "0"
      wait_col(1);
      keys[3][1] = 1'b1;
      repeat (6) @(negedge clk);
      reset = 1'b1;
      keys = '0;
      @(negedge clk);
      check4("abort_columnas", columnas, 4'b1110);
      check4("abort_digito", digito, 4'd0);
      check4("abort_op", {2'b00, que_operacion}, 4'd0);
      check4("abort_pulses", {2'b00, digito_en, operando_en}, 4'd0);
      reset = 1'b0;
      wait_col(1);
      repeat (30) @(negedge clk);
      check4("sb_empty", 4'(sb.size()), 4'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/teclado_matricial_calc.md
Name: teclado_matricial_calc

Overview:
Keypad front end for the calculator. It scans a 4x4 active-low matrix keypad, synchronizes and debounces the row lines, and decodes each press into exactly one event. A digit press produces a one-cycle digito_en pulse with the digit value. An operator press produces a one-cycle operando_en pulse with que_operacion, and these feed the operation control FSM.

Parameters:
SCAN_DIV, 16, clk cycles each column is driven before moving to the next (>=4)
DEBOUNCE_CYCLES, 1000, consecutive stable cycles required to accept a press or a release (>=2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
filas  input  4  keypad rows, active-low, asynchronous to clk, pulled up externally
columnas  output  4  keypad column drive, one-hot active-low
digito  output  4  last decoded digit 0..9, held between events
digito_en  output  1  one-cycle pulse: new digit valid this cycle
que_operacion  output  2  last operator: 1=suma, 2=resta, 3=igual, 0=none; held between events
operando_en  output  1  one-cycle pulse: new operator valid this cycle

Behaviour:
- Reset (clk edge with reset=1): state=SCAN, col_idx=0, columnas=4'b1110, digito=0, que_operacion=0, digito_en=0, operando_en=0, all counters=0. Reset applied mid-debounce or mid-hold aborts the press with no pulse.
- filas passes through a 2-flop synchronizer. Every decision uses the synchronized value rs. Input-to-rs latency is 2 cycles.
- Keymap (row,col), with row0=filas[0] and col0=columnas[0]:
  - r0: 1 2 3 suma
  - r1: 4 5 6 resta
  - r2: 7 8 9 igual
  - r3: none 0 none none
- "none" keys are accepted and debounced like any key, but they emit no pulse.
- If several rows read low, the lowest row index wins.
- FSM states:
  - SCAN: drive the column col_idx low. A dwell counter counts 0..SCAN_DIV-1.
    - At dwell==SCAN_DIV-1, if rs!=4'hF: latch the row (priority encoded) and the column, clear deb_cnt, go to DEBOUNCE.
    - Otherwise advance col_idx (3 wraps to 0) and reset the dwell counter.
  - DEBOUNCE: the column stays driven. deb_cnt increments each cycle while rs[latched_row]==0.
    - If rs[latched_row]==1 before deb_cnt reaches DEBOUNCE_CYCLES-1: return to SCAN on the same column with dwell cleared. No pulse.
    - At deb_cnt==DEBOUNCE_CYCLES-1 with the row still low: go to EMIT.
  - EMIT: lasts exactly one cycle.
    - Digit key: the registered outputs update on this edge, so digito_en=1 and the new digito are visible in the following cycle.
    - Operator key: operando_en=1 and que_operacion are updated in the same way.
    - "none" key: no output change.
    - Then go to HOLD.
  - HOLD: the column stays driven and deb_cnt is cleared on entry.
    - deb_cnt counts consecutive cycles with rs==4'hF and clears on any low row.
    - At DEBOUNCE_CYCLES-1: advance col_idx, clear dwell, go to SCAN.
    - Holding a key therefore never repeats. A second key pressed during HOLD is ignored until every row is released.
- Pulses are exactly one cycle wide. digito_en and operando_en are never high in the same cycle.
- digito and que_operacion change only on their own event.
- All outputs are registered. columnas changes only on state or column transitions.
- Counter widths: the dwell counter is clog2(SCAN_DIV). deb_cnt is clog2(DEBOUNCE_CYCLES) and saturates, with no wrap.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_CYCLES=8.
1. Reset released, no key -> columnas cycles 1110, 1101, 1011, 0111, 1110, each for 4 cycles. No pulses. digito=0, que_operacion=0.
2. Key "5" (r1,c1) pulled low on filas[1] whenever columnas[1]=0, held 40 cycles -> exactly one digito_en pulse with digito=5. columnas frozen at 1101 until 8 released cycles have elapsed, then it moves to 1011.
3. Bounce: key "+" (r0,c3) toggling every 3 cycles for 20 cycles, then stable for 20 cycles -> no pulse during the bounce. Then one operando_en pulse with que_operacion=1.
4. Sequence 7, resta, 2, igual, each pressed 20 and released 20 cycles -> four pulses in order:
   - digito=7
   - que_operacion=2
   - digito=2
   - que_operacion=3
   digito stays at 2 across the igual pulse.
5. Keys (r0,c0) and (r2,c0) pressed together -> digito=1 (lower row wins), one pulse only. A press of "9" during HOLD is ignored until all rows are released.
6. reset asserted 3 cycles into DEBOUNCE of key "0" -> no pulse. Outputs at reset values and columnas=1110 on the next cycle. Scanning resumes after reset drops.
